vga_pipe_sched: RTL

VGA_PIPE_SCHED -- requirements
Module: vga_pipe_sched

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_pix_tick.sv | 47 ++++
 rtl/vga_pipe_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared definitions for the VGA pixel pipeline scheduler:
//                FSM state encoding, FIFO depth and watermark defaults, and
//                the occupancy saturation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int unsigned c_DEPTH_DEF   = 16;
    localparam int unsigned c_LOW_WM_DEF  = 8;
    localparam int unsigned c_HIGH_WM_DEF = 12;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_FILL  = 2'd1,
        ST_IDLE  = 2'd2
    } vga_state_t;

    // Occupancy reports above the FIFO depth are clamped to the depth.
    function automatic logic [4:0] sat_nword(input logic [4:0] nword,
                                             input logic [4:0] depth);
        return (nword > depth) ? depth : nword;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pix_tick.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pix_tick
//  Description : Pixel-period counter and registered pixel tick. The period
//                is 4 clocks, or 8 clocks at half dot rate; the rate select
//                is only sampled when the counter wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pix_tick (
    input  logic clk,
    input  logic rst,
    input  logic i_div2,
    output logic o_tick_pre,
    output logic o_tick
);

    logic [2:0] r_cnt;
    logic       r_div2;
    logic       r_tick;
    logic [2:0] w_limit;
    logic       w_wrap;

    assign w_limit    = r_div2 ? 3'd7 : 3'd3;
    assign w_wrap     = (r_cnt == w_limit);
    // One cycle ahead of the registered tick, so downstream registers line up.
    assign o_tick_pre = (r_cnt == 3'd1);
    assign o_tick     = r_tick;

    // Count every clock, wrap at the period limit, latch the rate at the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 3'd0;
            r_div2 <= i_div2;
            r_tick <= 1'b0;
        end else begin
            r_tick <= o_tick_pre;
            if (w_wrap) begin
                r_cnt  <= 3'd0;
                r_div2 <= i_div2;
            end else begin
                r_cnt  <= r_cnt + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_pipe_sched.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pipe_sched
//  Description : Schedules pixel FIFO refill (enable_fill) against pixel
//                consumption (read_fifo / enable_pal_dac) with watermark
//                hysteresis, never stalling an in-flight memory cycle, and
//                keeps sticky underrun / overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pipe_sched
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH   = c_DEPTH_DEF,
    parameter int unsigned LOW_WM  = c_LOW_WM_DEF,
    parameter int unsigned HIGH_WM = c_HIGH_WM_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x_dotclockdiv2,
    input  logic [4:0] fifo_nword,
    input  logic       csr_stb,
    input  logic       clr_err,
    output logic       enable_fill,
    output logic       read_fifo,
    output logic       enable_pal_dac,
    output logic       underrun,
    output logic       overflow
);

    localparam logic [4:0] c_DEPTH = 5'(DEPTH);
    localparam logic [4:0] c_LOW   = 5'(LOW_WM);
    localparam logic [4:0] c_HIGH  = 5'(HIGH_WM);

    vga_state_t r_state;
    vga_state_t w_state_nxt;

    logic [3:0] r_stb_sr;
    logic [3:0] w_stb_sr_nxt;
    logic       w_busy;
    logic [4:0] w_nword;
    logic       w_tick_pre;
    logic       w_tick;

    logic       w_fill_nxt;
    logic       w_rd_nxt;
    logic       w_ur_set;
    logic       w_ov_set;

    logic       r_fill;
    logic       r_rd;
    logic       r_ur;
    logic       r_ov;

    vga_pix_tick u_pix_tick (
        .clk        (clk),
        .rst        (rst),
        .i_div2     (x_dotclockdiv2),
        .o_tick_pre (w_tick_pre),
        .o_tick     (w_tick)
    );

    assign w_nword      = sat_nword(fifo_nword, c_DEPTH);
    // Busy is judged on the shift register contents the outputs will see,
    // so enable_fill covers exactly the four cycles after each strobe.
    assign w_stb_sr_nxt = {r_stb_sr[2:0], csr_stb};
    assign w_busy       = |w_stb_sr_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next output values and error-flag set conditions.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = 1'b0;
        w_rd_nxt    = 1'b0;
        w_ur_set    = 1'b0;
        w_ov_set    = 1'b0;

        case (r_state)
            ST_PRIME, ST_FILL: begin
                if ((w_nword >= c_HIGH) && !w_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_nword < c_LOW) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_PRIME;
            end
        endcase

        // Refill follows the state being entered; a pending memory cycle
        // always keeps it high.
        w_fill_nxt = (w_state_nxt != ST_IDLE) || w_busy;

        // Pops start only once the FIFO has been primed; an empty FIFO at a
        // tick repeats the last pixel and flags underrun.
        if (w_tick_pre && (r_state != ST_PRIME)) begin
            w_rd_nxt = (w_nword != 5'd0);
            w_ur_set = (w_nword == 5'd0);
        end

        w_ov_set = w_fill_nxt && (w_nword == c_DEPTH) && !w_rd_nxt;
    end

    // Strobe history, registered outputs and sticky flags (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stb_sr <= 4'd0;
            r_fill   <= 1'b0;
            r_rd     <= 1'b0;
            r_ur     <= 1'b0;
            r_ov     <= 1'b0;
        end else begin
            r_stb_sr <= w_stb_sr_nxt;
            r_fill   <= w_fill_nxt;
            r_rd     <= w_rd_nxt;
            if (w_ur_set) begin
                r_ur <= 1'b1;
            end else if (clr_err) begin
                r_ur <= 1'b0;
            end
            if (w_ov_set) begin
                r_ov <= 1'b1;
            end else if (clr_err) begin
                r_ov <= 1'b0;
            end
        end
    end

    assign enable_fill    = r_fill;
    assign read_fifo      = r_rd;
    assign enable_pal_dac = w_tick;
    assign underrun       = r_ur;
    assign overflow       = r_ov;

endmodule
`default_nettype wire
